traffic_light_ctrl: RTL and testbench

Four-way traffic-light controller that drives the `start`/`enable`/`delay` inputs of the shared delay counter and consumes its `done` output. It sequences north–south and east–west lights through green, yellow and all-red phases, and inserts a pedestrian WALK phase on request. It sits beside the delay counter in the integration top; each phase duration is expressed in delay-counter ticks, each tick being one `BASIC_PERIOD` of that counter.

---
 rtl/traffic_pkg.sv | 48 ++++
 rtl/traffic_light_ctrl.sv | 89 ++++++++
 tb/tb_traffic_light_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the four-way traffic-light controller:
// state encoding, one-hot lamp codes and default phase durations.
package traffic_pkg;

    typedef enum logic [3:0] {
        INIT      = 4'd0,
        NS_GREEN  = 4'd1,
        NS_YELLOW = 4'd2,
        ALL_RED1  = 4'd3,
        EW_GREEN  = 4'd4,
        EW_YELLOW = 4'd5,
        ALL_RED2  = 4'd6,
        WALK      = 4'd7
    } state_t;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam logic [7:0] DEF_T_GREEN  = 8'd200;
    localparam logic [7:0] DEF_T_YELLOW = 8'd50;
    localparam logic [7:0] DEF_T_ALLRED = 8'd20;
    localparam logic [7:0] DEF_T_WALK   = 8'd150;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } lamps_t;

    // Any light not named by the state shows red.
    function automatic lamps_t lamps_of(input state_t s);
        lamps_t l;
        l.ns   = RED;
        l.ew   = RED;
        l.walk = 1'b0;
        case (s)
            NS_GREEN:  l.ns   = GREEN;
            NS_YELLOW: l.ns   = YELLOW;
            EW_GREEN:  l.ew   = GREEN;
            EW_YELLOW: l.ew   = YELLOW;
            WALK:      l.walk = 1'b1;
            default:   ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl.sv
// Four-way traffic-light sequencer driving an external delay counter,
// with an optional pedestrian WALK phase after either all-red clearance.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter logic [7:0] T_GREEN  = DEF_T_GREEN,
    parameter logic [7:0] T_YELLOW = DEF_T_YELLOW,
    parameter logic [7:0] T_ALLRED = DEF_T_ALLRED,
    parameter logic [7:0] T_WALK   = DEF_T_WALK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_req,
    input  logic       done,
    output logic       start,
    output logic       enable,
    output logic [7:0] delay,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [3:0] state
);

    state_t     cur;
    state_t     nxt;
    state_t     walk_next;
    logic       ped_pending;
    logic       timed_done;
    logic [7:0] nxt_delay;
    lamps_t     lamps;

    // done may still be high from the previous interval while start is pulsing.
    always_comb begin
        timed_done = done && !start;
        nxt        = cur;
        nxt_delay  = '0;
        case (cur)
            INIT:      nxt = ALL_RED2;
            NS_GREEN:  if (timed_done) nxt = NS_YELLOW;
            NS_YELLOW: if (timed_done) nxt = ALL_RED1;
            ALL_RED1:  if (timed_done) nxt = ped_pending ? WALK : EW_GREEN;
            EW_GREEN:  if (timed_done) nxt = EW_YELLOW;
            EW_YELLOW: if (timed_done) nxt = ALL_RED2;
            ALL_RED2:  if (timed_done) nxt = ped_pending ? WALK : NS_GREEN;
            WALK:      if (timed_done) nxt = walk_next;
            default:   nxt = INIT;
        endcase
        case (nxt)
            NS_GREEN, EW_GREEN:   nxt_delay = T_GREEN;
            NS_YELLOW, EW_YELLOW: nxt_delay = T_YELLOW;
            ALL_RED1, ALL_RED2:   nxt_delay = T_ALLRED;
            WALK:                 nxt_delay = T_WALK;
            default:              nxt_delay = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= INIT;
            start       <= 1'b0;
            enable      <= 1'b0;
            delay       <= '0;
            ped_pending <= 1'b0;
            walk_next   <= NS_GREEN;
            lamps       <= lamps_of(INIT);
        end else begin
            enable <= 1'b1;
            start  <= (nxt != cur);
            if (nxt != cur) begin
                cur   <= nxt;
                delay <= nxt_delay;
                lamps <= lamps_of(nxt);
            end
            // Entering WALK clears the request even if the button is still held.
            if (nxt == WALK && cur != WALK) begin
                walk_next   <= (cur == ALL_RED1) ? EW_GREEN : NS_GREEN;
                ped_pending <= 1'b0;
            end else if (ped_req && cur != WALK) begin
                ped_pending <= 1'b1;
            end
        end
    end

    assign state    = cur;
    assign ns_light = lamps.ns;
    assign ew_light = lamps.ew;
    assign walk     = lamps.walk;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl with a behavioural delay
// counter (period 5) and a phase-timing reference model.
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    localparam int P = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ped_req = 1'b0;
    logic       done;
    logic       start;
    logic       enable;
    logic [7:0] delay;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [3:0] state;

    int  checks = 0;
    int  errors = 0;
    int  cnt = 0;
    logic cnt_done = 1'b0;
    logic force_done = 1'b0;

    assign done = cnt_done | force_done;

    traffic_light_ctrl #(
        .T_GREEN (8'd4),
        .T_YELLOW(8'd2),
        .T_ALLRED(8'd1),
        .T_WALK  (8'd3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ped_req (ped_req),
        .done    (done),
        .start   (start),
        .enable  (enable),
        .delay   (delay),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .walk    (walk),
        .state   (state)
    );

    always #5 clk = ~clk;

    // Delay counter: load d*P ticks of work on start, raise done once it runs out.
    always @(posedge clk) begin
        if (!enable) begin
            cnt      <= 0;
            cnt_done <= 1'b0;
        end else if (start) begin
            cnt      <= int'(delay) * P;
            cnt_done <= 1'b0;
        end else if (cnt == 0) begin
            cnt_done <= 1'b1;
        end else begin
            cnt <= cnt - 1;
        end
    end

    typedef struct {
        bit         pulse;
        bit         hold;
        int         gap;
        int         dly;
        logic [2:0] ns;
        logic [2:0] ew;
        bit         wlk;
        int         wcyc;
    } vec_t;

    function automatic vec_t mk(input bit p, input bit h, input int g, input int d,
                                input logic [2:0] n, input logic [2:0] e,
                                input bit w, input int wc);
        vec_t v;
        v.pulse = p; v.hold = h; v.gap = g; v.dly = d;
        v.ns = n; v.ew = e; v.wlk = w; v.wcyc = wc;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input bit pulse, input bit hold, output int gap, output int wcnt);
        gap = 0;
        wcnt = 0;
        ped_req = pulse | hold;
        do begin
            if (walk) wcnt++;
            tick();
            gap++;
            if (gap == 1) ped_req = hold;
            check("ns_onehot", $countones(ns_light), 1);
            check("ew_onehot", $countones(ew_light), 1);
            check("both_not_red", int'(ns_light != RED && ew_light != RED), 0);
        end while (!start && gap < 200);
        check("start_seen", start, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"}, state, INIT);
        check({tag, "_enable"}, enable, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_delay"}, delay, 0);
        check({tag, "_ns"}, ns_light, RED);
        check({tag, "_ew"}, ew_light, RED);
        check({tag, "_walk"}, walk, 0);
    endtask

    // Called in the first cycle after reset has been released.
    task automatic restart_check();
        int gap, wc;
        check_reset_state("released");
        tick();
        check("first_start", start, 1);
        check("first_delay", delay, 1);
        check("first_state", state, ALL_RED2);
        wait_start(1'b0, 1'b0, gap, wc);
        check("ar2_to_nsg_gap", gap, 8);
        check("nsg_delay", delay, 4);
        check("nsg_ns", ns_light, GREEN);
        check("nsg_ew", ew_light, RED);
    endtask

    // Reference model: phases as timed slots of d*P+3 cycles.
    localparam int PH_NSG = 0, PH_NSY = 1, PH_AR1 = 2, PH_EWG = 3,
                   PH_EWY = 4, PH_AR2 = 5, PH_WALK = 6;
    int         dur_tab[7]   = '{4, 2, 1, 4, 2, 1, 3};
    logic [2:0] ns_tab[7]    = '{GREEN, YELLOW, RED, RED, RED, RED, RED};
    logic [2:0] ew_tab[7]    = '{RED, RED, RED, GREEN, YELLOW, RED, RED};
    state_t     st_tab[7]    = '{NS_GREEN, NS_YELLOW, ALL_RED1, EW_GREEN,
                                 EW_YELLOW, ALL_RED2, WALK};
    int  m_phase, m_remain, m_resume, m_delay;
    bit  m_init, m_pend, m_start;

    task automatic model_enter(input int ph);
        m_phase  = ph;
        m_remain = dur_tab[ph] * P + 3;
        m_start  = 1'b1;
        m_delay  = dur_tab[ph];
    endtask

    task automatic model_step(input bit ped);
        int  old_ph = m_phase;
        bit  old_pend = m_pend;
        bit  to_walk = 1'b0;
        m_start = 1'b0;
        if (m_init) begin
            m_init = 1'b0;
            old_ph = -1;
            model_enter(PH_AR2);
        end else begin
            m_remain--;
            if (m_remain == 0) begin
                case (old_ph)
                    PH_AR1: begin
                        to_walk = old_pend;
                        m_resume = PH_EWG;
                        model_enter(old_pend ? PH_WALK : PH_EWG);
                    end
                    PH_AR2: begin
                        to_walk = old_pend;
                        m_resume = PH_NSG;
                        model_enter(old_pend ? PH_WALK : PH_NSG);
                    end
                    PH_WALK: model_enter(m_resume);
                    default: model_enter(old_ph + 1);
                endcase
            end
        end
        if (to_walk) m_pend = 1'b0;
        else if (ped && old_ph != PH_WALK) m_pend = 1'b1;
    endtask

    vec_t vecs[$];

    initial begin
        int gap, wc;
        bit hold_mode;

        vecs.push_back(mk(0, 0, 23, 2, YELLOW, RED,    0, 0));
        vecs.push_back(mk(0, 0, 13, 1, RED,    RED,    0, 0));
        vecs.push_back(mk(0, 0,  8, 4, RED,    GREEN,  0, 0));
        vecs.push_back(mk(0, 0, 23, 2, RED,    YELLOW, 0, 0));
        vecs.push_back(mk(0, 0, 13, 1, RED,    RED,    0, 0));
        vecs.push_back(mk(0, 0,  8, 4, GREEN,  RED,    0, 0));
        vecs.push_back(mk(0, 0, 23, 2, YELLOW, RED,    0, 0));
        vecs.push_back(mk(0, 0, 13, 1, RED,    RED,    0, 0));
        vecs.push_back(mk(0, 0,  8, 4, RED,    GREEN,  0, 0));
        vecs.push_back(mk(1, 0, 23, 2, RED,    YELLOW, 0, 0));
        vecs.push_back(mk(0, 0, 13, 1, RED,    RED,    0, 0));
        vecs.push_back(mk(0, 0,  8, 3, RED,    RED,    1, 0));
        vecs.push_back(mk(0, 0, 18, 4, GREEN,  RED,    0, 18));
        vecs.push_back(mk(0, 1, 23, 2, YELLOW, RED,    0, 0));
        vecs.push_back(mk(0, 1, 13, 1, RED,    RED,    0, 0));
        vecs.push_back(mk(0, 1,  8, 3, RED,    RED,    1, 0));
        vecs.push_back(mk(0, 1, 18, 4, RED,    GREEN,  0, 18));
        vecs.push_back(mk(0, 1, 23, 2, RED,    YELLOW, 0, 0));
        vecs.push_back(mk(0, 1, 13, 1, RED,    RED,    0, 0));
        vecs.push_back(mk(0, 1,  8, 3, RED,    RED,    1, 0));
        vecs.push_back(mk(0, 1, 18, 4, GREEN,  RED,    0, 18));
        vecs.push_back(mk(0, 0, 23, 2, YELLOW, RED,    0, 0));
        vecs.push_back(mk(0, 0, 13, 1, RED,    RED,    0, 0));
        vecs.push_back(mk(0, 0,  8, 4, RED,    GREEN,  0, 0));

        reset = 1'b1;
        repeat (3) tick();
        check_reset_state("in_reset");
        reset = 1'b0;
        restart_check();

        foreach (vecs[i]) begin
            wait_start(vecs[i].pulse, vecs[i].hold, gap, wc);
            check($sformatf("v%0d_gap", i), gap, vecs[i].gap);
            check($sformatf("v%0d_delay", i), delay, vecs[i].dly);
            check($sformatf("v%0d_ns", i), ns_light, vecs[i].ns);
            check($sformatf("v%0d_ew", i), ew_light, vecs[i].ew);
            check($sformatf("v%0d_walk", i), walk, vecs[i].wlk);
            check($sformatf("v%0d_walk_cycles", i), wc, vecs[i].wcyc);
            if (vecs[i].wlk) check($sformatf("v%0d_pending", i), dut.ped_pending, 0);
        end

        // done forced high during the EW_GREEN start cycle must not advance.
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("forced_done_state", state, EW_GREEN);
        check("forced_done_start", start, 0);
        wait_start(1'b0, 1'b0, gap, wc);
        check("forced_done_gap", gap + 1, 23);
        check("forced_done_ew", ew_light, YELLOW);

        wait_start(1'b0, 1'b0, gap, wc);
        check("pre_rst_ar2_gap", gap, 13);
        wait_start(1'b0, 1'b0, gap, wc);
        check("pre_rst_nsg_gap", gap, 8);
        wait_start(1'b0, 1'b0, gap, wc);
        check("pre_rst_nsy_gap", gap, 23);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check_reset_state("mid_rst");
        reset = 1'b0;
        restart_check();

        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        m_init = 1'b1;
        m_pend = 1'b0;
        m_phase = PH_AR2;
        m_resume = PH_NSG;
        hold_mode = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 149) == 0) hold_mode = ~hold_mode;
            ped_req = hold_mode | ($urandom_range(0, 24) == 0);
            tick();
            model_step(ped_req);
            check("rnd_state", state, st_tab[m_phase]);
            check("rnd_ns", ns_light, ns_tab[m_phase]);
            check("rnd_ew", ew_light, ew_tab[m_phase]);
            check("rnd_walk", walk, int'(m_phase == PH_WALK));
            check("rnd_start", start, m_start);
            check("rnd_delay", delay, m_delay);
            check("rnd_enable", enable, 1);
            check("rnd_pending", dut.ped_pending, m_pend);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
